// File: rtl/acc_pkg.sv
// Shared opcode definitions for the accumulator register bank.
package acc_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP     = 4'd0,
        OP_LOAD_ZX = 4'd1,
        OP_LOAD_SX = 4'd2,
        OP_LOAD_HI = 4'd3,
        OP_CLR     = 4'd4,
        OP_INC     = 4'd5,
        OP_DEC     = 4'd6,
        OP_SHL     = 4'd7,
        OP_SHR     = 4'd8,
        OP_ROL     = 4'd9,
        OP_ROR     = 4'd10,
        OP_ASR     = 4'd11
    } acc_op_e;

    // Codes above OP_ASR are reserved and must raise op_err.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op <= OP_ASR);
    endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational next-value and carry logic for one register of the bank.
module acc_alu
    import acc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IN_W   = 4
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] cur_val,
    input  logic [IN_W-1:0]   din,
    output logic [DATA_W-1:0] nxt_val,
    output logic              nxt_c,
    output logic              wr_en
);

    always_comb begin
        nxt_val = cur_val;
        nxt_c   = 1'b0;
        wr_en   = 1'b1;
        case (op)
            OP_LOAD_ZX: nxt_val = DATA_W'(din);
            OP_LOAD_SX: nxt_val = DATA_W'($signed(din));
            // Part-select covers the whole word when IN_W == DATA_W.
            OP_LOAD_HI: nxt_val[DATA_W-1 -: IN_W] = din;
            OP_CLR:     nxt_val = '0;
            OP_INC:     {nxt_c, nxt_val} = (DATA_W+1)'(cur_val) + (DATA_W+1)'(1);
            OP_DEC: begin
                nxt_val = cur_val - DATA_W'(1);
                nxt_c   = (cur_val == '0);
            end
            OP_SHL: begin
                nxt_val = cur_val << 1;
                nxt_c   = cur_val[DATA_W-1];
            end
            OP_SHR: begin
                nxt_val = cur_val >> 1;
                nxt_c   = cur_val[0];
            end
            OP_ROL: begin
                nxt_val = {cur_val[DATA_W-2:0], cur_val[DATA_W-1]};
                nxt_c   = cur_val[DATA_W-1];
            end
            OP_ROR: begin
                nxt_val = {cur_val[0], cur_val[DATA_W-1:1]};
                nxt_c   = cur_val[0];
            end
            OP_ASR: begin
                nxt_val = $unsigned($signed(cur_val) >>> 1);
                nxt_c   = cur_val[0];
            end
            default: wr_en = 1'b0;
        endcase
    end

endmodule

// File: rtl/acc_reg_bank.sv
// Register bank with load/arith/shift ops, Z/C/N flags, error pulse and two async read ports.
module acc_reg_bank
    import acc_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int IN_W     = 4,
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              reg_clk,
    input  logic              reg_rst,
    input  logic              reg_en,
    input  logic [OP_W-1:0]   reg_op,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [IN_W-1:0]   data_in,
    input  logic [SEL_W-1:0]  rd_sel_a,
    input  logic [SEL_W-1:0]  rd_sel_b,
    output logic [DATA_W-1:0] data_out_a,
    output logic [DATA_W-1:0] data_out_b,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_n,
    output logic              op_err
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] cur_val;
    logic [DATA_W-1:0] nxt_val;
    logic              nxt_c;
    logic              alu_wr_en;
    logic              legal;

    assign legal = is_legal_op(reg_op) && (int'(wr_sel) < NUM_REGS);

    // Select muxes compare against every index so out-of-range selects yield 0.
    always_comb begin
        cur_val    = '0;
        data_out_a = '0;
        data_out_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_sel == SEL_W'(i))   cur_val    = regs[i];
            if (rd_sel_a == SEL_W'(i)) data_out_a = regs[i];
            if (rd_sel_b == SEL_W'(i)) data_out_b = regs[i];
        end
    end

    acc_alu #(
        .DATA_W (DATA_W),
        .IN_W   (IN_W)
    ) u_alu (
        .op      (reg_op),
        .cur_val (cur_val),
        .din     (data_in),
        .nxt_val (nxt_val),
        .nxt_c   (nxt_c),
        .wr_en   (alu_wr_en)
    );

    always_ff @(posedge reg_clk or posedge reg_rst) begin
        if (reg_rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_n <= 1'b0;
            op_err <= 1'b0;
        end else begin
            op_err <= 1'b0;
            if (reg_en) begin
                if (!legal) begin
                    op_err <= 1'b1;
                end else if (alu_wr_en) begin
                    for (int i = 0; i < NUM_REGS; i++)
                        if (wr_sel == SEL_W'(i)) regs[i] <= nxt_val;
                    flag_z <= (nxt_val == '0);
                    flag_c <= nxt_c;
                    flag_n <= nxt_val[DATA_W-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_acc_reg_bank.sv
// Directed self-checking bench for acc_reg_bank (8-bit x4 main instance, 3-register instance for select errors).
module tb_acc_reg_bank;

    logic       reg_clk;
    logic       reg_rst;
    logic       reg_en;
    logic       reg_en3;
    logic [3:0] reg_op;
    logic [1:0] wr_sel;
    logic [3:0] data_in;
    logic [1:0] rd_sel_a;
    logic [1:0] rd_sel_b;
    logic [7:0] data_out_a, data_out_b;
    logic       flag_z, flag_c, flag_n, op_err;
    logic [7:0] data_out_a3, data_out_b3;
    logic       flag_z3, flag_c3, flag_n3, op_err3;

    int tests_run = 0;
    int tests_failed = 0;

    acc_reg_bank #(.DATA_W(8), .IN_W(4), .NUM_REGS(4)) u_dut (
        .reg_clk    (reg_clk),
        .reg_rst    (reg_rst),
        .reg_en     (reg_en),
        .reg_op     (reg_op),
        .wr_sel     (wr_sel),
        .data_in    (data_in),
        .rd_sel_a   (rd_sel_a),
        .rd_sel_b   (rd_sel_b),
        .data_out_a (data_out_a),
        .data_out_b (data_out_b),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .flag_n     (flag_n),
        .op_err     (op_err)
    );

    acc_reg_bank #(.DATA_W(8), .IN_W(4), .NUM_REGS(3)) u_dut3 (
        .reg_clk    (reg_clk),
        .reg_rst    (reg_rst),
        .reg_en     (reg_en3),
        .reg_op     (reg_op),
        .wr_sel     (wr_sel),
        .data_in    (data_in),
        .rd_sel_a   (rd_sel_a),
        .rd_sel_b   (rd_sel_b),
        .data_out_a (data_out_a3),
        .data_out_b (data_out_b3),
        .flag_z     (flag_z3),
        .flag_c     (flag_c3),
        .flag_n     (flag_n3),
        .op_err     (op_err3)
    );

    initial reg_clk = 1'b0;
    always #5 reg_clk = ~reg_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkFlags(input string tag, input logic z, input logic c, input logic n);
        checkOutput({tag, ".z"}, 32'(flag_z), 32'(z));
        checkOutput({tag, ".c"}, 32'(flag_c), 32'(c));
        checkOutput({tag, ".n"}, 32'(flag_n), 32'(n));
    endtask

    // Drive on the falling edge, return 1 time unit after the next rising edge.
    task automatic applyStimulus(input logic en, input logic [3:0] op,
                                 input logic [1:0] sel, input logic [3:0] din);
        @(negedge reg_clk);
        reg_en  = en;
        reg_op  = op;
        wr_sel  = sel;
        data_in = din;
        @(posedge reg_clk);
        #1;
    endtask

    localparam logic [3:0] NOP = 4'd0, LZX = 4'd1, LSX = 4'd2, LHI = 4'd3, CLR = 4'd4,
                           INC = 4'd5, DEC = 4'd6, SHL = 4'd7, SHR = 4'd8, ROL = 4'd9,
                           ROR = 4'd10, ASR = 4'd11;

    logic [3:0] sh_op  [5] = '{SHL, SHR, ROR, ASR, ROL};
    logic [7:0] sh_exp [5] = '{8'h02, 8'h40, 8'hC0, 8'hC0, 8'h03};
    logic       sh_n   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        reg_rst = 1'b1; reg_en = 1'b0; reg_en3 = 1'b0; reg_op = NOP;
        wr_sel = '0; data_in = '0; rd_sel_a = 2'd0; rd_sel_b = 2'd1;
        #2;
        checkOutput("rst.out_a", 32'(data_out_a), 32'h00);
        checkOutput("rst.out_b", 32'(data_out_b), 32'h00);
        checkFlags("rst", 1'b0, 1'b0, 1'b0);
        checkOutput("rst.op_err", 32'(op_err), 32'h0);
        @(negedge reg_clk);
        reg_rst = 1'b0;

        // Loads
        applyStimulus(1'b1, LZX, 2'd0, 4'hA);
        checkOutput("ldzx.r0", 32'(data_out_a), 32'h0A);
        checkFlags("ldzx", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, LSX, 2'd1, 4'hA);
        checkOutput("ldsx.r1", 32'(data_out_b), 32'hFA);
        checkFlags("ldsx", 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, LHI, 2'd0, 4'h3);
        checkOutput("ldhi.r0", 32'(data_out_a), 32'h3A);
        checkFlags("ldhi", 1'b0, 1'b0, 1'b0);

        // Wrap-around
        rd_sel_b = 2'd2;
        applyStimulus(1'b1, LSX, 2'd2, 4'hF);
        checkOutput("wrap.ld", 32'(data_out_b), 32'hFF);
        applyStimulus(1'b1, INC, 2'd2, 4'h0);
        checkOutput("wrap.inc", 32'(data_out_b), 32'h00);
        checkFlags("wrap.inc", 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, DEC, 2'd2, 4'h0);
        checkOutput("wrap.dec", 32'(data_out_b), 32'hFF);
        checkFlags("wrap.dec", 1'b0, 1'b1, 1'b1);

        // Shifts on 0x81 in r3, reloaded before each op
        rd_sel_b = 2'd3;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, LZX, 2'd3, 4'h1);
            applyStimulus(1'b1, LHI, 2'd3, 4'h8);
            checkOutput($sformatf("shift%0d.pre", k), 32'(data_out_b), 32'h81);
            applyStimulus(1'b1, sh_op[k], 2'd3, 4'h0);
            checkOutput($sformatf("shift%0d.val", k), 32'(data_out_b), 32'(sh_exp[k]));
            checkFlags($sformatf("shift%0d", k), 1'b0, 1'b1, sh_n[k]);
        end

        // Read-during-write returns the old value until the edge
        applyStimulus(1'b1, LZX, 2'd0, 4'hA);
        @(negedge reg_clk);
        reg_en = 1'b1; reg_op = LZX; wr_sel = 2'd0; data_in = 4'h7;
        #1;
        checkOutput("rdw.before", 32'(data_out_a), 32'h0A);
        @(posedge reg_clk);
        #1;
        checkOutput("rdw.after", 32'(data_out_a), 32'h07);
        applyStimulus(1'b0, INC, 2'd0, 4'h0);
        checkOutput("hold.r0", 32'(data_out_a), 32'h07);
        checkOutput("hold.op_err", 32'(op_err), 32'h0);
        checkFlags("hold", 1'b0, 1'b0, 1'b0);

        // Reserved opcode on r1
        rd_sel_b = 2'd1;
        applyStimulus(1'b1, CLR, 2'd2, 4'h0);
        checkFlags("clr", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hC, 2'd1, 4'h5);
        checkOutput("rsv.op_err", 32'(op_err), 32'h1);
        checkOutput("rsv.r1", 32'(data_out_b), 32'hFA);
        checkFlags("rsv", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, NOP, 2'd0, 4'h0);
        checkOutput("rsv.op_err_drop", 32'(op_err), 32'h0);
        checkFlags("nop", 1'b1, 1'b0, 1'b0);

        // Out-of-range write select on the 3-register instance
        @(negedge reg_clk);
        reg_en = 1'b0; reg_en3 = 1'b1; reg_op = LSX; wr_sel = 2'd1; data_in = 4'h8;
        rd_sel_a = 2'd1; rd_sel_b = 2'd3;
        @(posedge reg_clk); #1;
        checkOutput("sel3.ld", 32'(data_out_a3), 32'hF8);
        @(negedge reg_clk);
        reg_op = INC; wr_sel = 2'd3;
        @(posedge reg_clk); #1;
        checkOutput("sel3.op_err", 32'(op_err3), 32'h1);
        checkOutput("sel3.r1", 32'(data_out_a3), 32'hF8);
        checkOutput("sel3.rd_oor", 32'(data_out_b3), 32'h00);
        checkOutput("sel3.z", 32'(flag_z3), 32'h0);
        checkOutput("sel3.c", 32'(flag_c3), 32'h0);
        checkOutput("sel3.n", 32'(flag_n3), 32'h1);
        @(negedge reg_clk);
        reg_en3 = 1'b0;
        @(posedge reg_clk); #1;
        checkOutput("sel3.op_err_drop", 32'(op_err3), 32'h0);

        // Async reset between edges
        rd_sel_a = 2'd2; rd_sel_b = 2'd3;
        applyStimulus(1'b1, LZX, 2'd3, 4'h5);
        applyStimulus(1'b1, LHI, 2'd3, 4'h5);
        checkOutput("ar.r3", 32'(data_out_b), 32'h55);
        applyStimulus(1'b1, DEC, 2'd2, 4'h0);
        checkFlags("ar.pre", 1'b0, 1'b1, 1'b1);
        @(negedge reg_clk);
        reg_en = 1'b0;
        #1 reg_rst = 1'b1;
        #1;
        checkOutput("ar.r3", 32'(data_out_b), 32'h00);
        checkOutput("ar.r2", 32'(data_out_a), 32'h00);
        checkFlags("ar", 1'b0, 1'b0, 1'b0);
        #1 reg_rst = 1'b0;
        applyStimulus(1'b1, LSX, 2'd3, 4'h9);
        checkOutput("ar.post", 32'(data_out_b), 32'hF9);
        checkFlags("ar.post", 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, INC, 2'd2, 4'h0);
        checkOutput("ar.inc", 32'(data_out_a), 32'h01);
        checkFlags("ar.inc", 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/acc_reg_bank.md
Name: acc_reg_bank

Overview:
- Parametrised successor to the single 8-bit zero-extending data register.
- Bank of NUM_REGS registers, DATA_W bits each, loaded from an IN_W-bit input bus.
- Supports zero-extend, sign-extend and upper-field loads, plus in-place clear, increment, decrement, shift and rotate.
- Holds Z/C/N status flags and provides two asynchronous read ports feeding the datapath and the display logic.

Parameters:
- DATA_W, 8, register width in bits; must satisfy DATA_W >= IN_W.
- IN_W, 4, width of the data_in load bus.
- NUM_REGS, 4, number of registers; need not be a power of two.
- SEL_W, $clog2(NUM_REGS) (minimum 1), width of the register select buses.

Ports:
- reg_clk  in  1  clock; all state changes on the rising edge.
- reg_rst  in  1  asynchronous, active-high reset.
- reg_en  in  1  operation enable.
- reg_op  in  4  operation code.
- wr_sel  in  SEL_W  target register for the operation.
- data_in  in  IN_W  load data.
- rd_sel_a  in  SEL_W  read port A select.
- rd_sel_b  in  SEL_W  read port B select.
- data_out_a  out  DATA_W  contents of the register selected by rd_sel_a.
- data_out_b  out  DATA_W  contents of the register selected by rd_sel_b.
- flag_z  out  1  zero flag: result of the last executed op was 0.
- flag_c  out  1  carry/borrow/shifted-out bit of the last executed op.
- flag_n  out  1  MSB of the result of the last executed op.
- op_err  out  1  registered one-cycle pulse flagging an illegal op or select.

Behaviour:
- Reset: reg_rst high clears all registers, flags and op_err immediately, with no clock edge needed. Reset wins over any op in progress. data_out_a and data_out_b then read 0.
- Ops execute only on a rising edge with reg_en=1. With reg_en=0, all state is held and op_err=0.
- Each op updates regs[wr_sel] and the flags in a single cycle.
- Opcodes (R = regs[wr_sel]):
  - 0 NOP: no register or flag change.
  - 1 LOAD_ZX: R = zero-extended data_in.
  - 2 LOAD_SX: R = data_in sign-extended from bit IN_W-1.
  - 3 LOAD_HI: R[DATA_W-1:DATA_W-IN_W] = data_in; lower bits kept. When IN_W==DATA_W this equals LOAD_ZX.
  - 4 CLR: R = 0.
  - 5 INC: R = R+1 mod 2^DATA_W; C = carry out.
  - 6 DEC: R = R-1 mod 2^DATA_W; C = borrow (set when R was 0).
  - 7 SHL: C = old MSB, LSB = 0.
  - 8 SHR (logical): C = old LSB, MSB = 0.
  - 9 ROL: C = old MSB.
  - 10 ROR: C = old LSB.
  - 11 ASR: C = old LSB, MSB replicated.
  - 12-15: reserved.
- Flags for every executed op except NOP:
  - Z = (result==0), N = result[DATA_W-1].
  - C is as listed above; loads and CLR force C=0.
  - Flags always reflect the most recent executed op, regardless of which register it targeted.
- Reserved op, or wr_sel >= NUM_REGS, with reg_en=1: no register or flag change; op_err=1 for exactly the following cycle.
- Reads are combinational from register state. Read-during-write returns the old value; the new value appears after the edge.
- rd_sel >= NUM_REGS reads 0.
- Only one write per cycle, so no write-write conflict exists.

Decomposition:
- Package acc_pkg holds the opcode localparams/enum (OP_NOP to OP_ASR) and an is_legal_op function.
- One sub-module, acc_alu: purely combinational.
  - Inputs: op, current value, data_in.
  - Outputs: next value, next C, a write-enable qualifier.
- acc_reg_bank holds the register array, flags, op_err and the read muxes.

Test Plan (DATA_W=8, IN_W=4, NUM_REGS=4):
- Loads: LOAD_ZX r0 0xA -> r0=0x0A, Z=0 N=0 C=0; then LOAD_SX r1 0xA -> r1=0xFA, N=1; then LOAD_HI r0 0x3 -> r0=0x3A.
- Wrap: LOAD_SX r2 0xF -> 0xFF; INC -> r2=0x00, Z=1 C=1; DEC -> r2=0xFF, C=1 N=1 Z=0.
- Shifts on 0x81 (LOAD_ZX 0x1 then LOAD_HI 0x8), reloaded before each op: SHL -> 0x02 C=1; SHR -> 0x40 C=1; ROR -> 0xC0 C=1; ASR -> 0xC0 C=1; ROL -> 0x03 C=1.
- Read-during-write: r0=0x0A, rd_sel_a=0, LOAD_ZX r0 0x7 -> data_out_a=0x0A before the edge, 0x07 after. reg_en=0 with op INC -> r0 stays 0x07.
- Errors: op=0xC on r1 -> op_err high one cycle, r1 and flags unchanged. Same result for wr_sel out of range with NUM_REGS=3.
- Async reset mid-sequence: r3=0x55, assert reg_rst between edges -> data_out_b (rd_sel_b=3)=0x00 and all flags 0 without a clock edge; after release, the first op executes normally.
